// File: rtl/traffic_sensor_arbiter.sv
// Car-sensor front end: two-flop synchronizers, per-street debouncers, and a
// min/max-hold arbiter that produces the TAORB grant level for the traffic FSM.
module traffic_sensor_arbiter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MIN_HOLD_CYCLES = 200_000_000,
  parameter int MAX_HOLD_CYCLES = 1_000_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic sensor_a_raw,
  input  logic sensor_b_raw,
  output logic taorb,
  output logic sensor_a_db,
  output logic sensor_b_db,
  output logic switch_pulse
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW  = $clog2(MAX_HOLD_CYCLES);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  MIN_LAST = HW'(MIN_HOLD_CYCLES - 1);
  localparam logic [HW-1:0]  MAX_LAST = HW'(MAX_HOLD_CYCLES - 1);

  typedef enum logic {GRANT_A, GRANT_B} state_t;

  logic [1:0]     sync_a;
  logic [1:0]     sync_b;
  logic [DBW-1:0] cnt_a;
  logic [DBW-1:0] cnt_b;
  state_t         state;
  logic [HW-1:0]  hold_cnt;
  logic           s_a;
  logic           s_b;
  logic           min_met;
  logic           max_met;

  assign s_a     = sync_a[1];
  assign s_b     = sync_b[1];
  assign min_met = (hold_cnt >= MIN_LAST);
  assign max_met = (hold_cnt == MAX_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[0], sensor_a_raw};
      sync_b <= {sync_b[0], sensor_b_raw};
    end
  end

  // Any cycle where the synchronized level agrees with the debounced one
  // restarts the count, so only an uninterrupted run can flip the output.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      cnt_a       <= '0;
      cnt_b       <= '0;
      sensor_a_db <= 1'b0;
      sensor_b_db <= 1'b0;
    end else begin
      if (s_a == sensor_a_db) begin
        cnt_a <= '0;
      end else if (cnt_a == DB_LAST) begin
        sensor_a_db <= s_a;
        cnt_a       <= '0;
      end else begin
        cnt_a <= cnt_a + DBW'(1);
      end

      if (s_b == sensor_b_db) begin
        cnt_b <= '0;
      end else if (cnt_b == DB_LAST) begin
        sensor_b_db <= s_b;
        cnt_b       <= '0;
      end else begin
        cnt_b <= cnt_b + DBW'(1);
      end
    end
  end

  // Arbiter: a contested grant only yields once max_met; an uncontested
  // request is honoured as soon as the minimum hold has elapsed.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state        <= GRANT_A;
      taorb        <= 1'b1;
      hold_cnt     <= '0;
      switch_pulse <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      if (hold_cnt != MAX_LAST) hold_cnt <= hold_cnt + HW'(1);
      case (state)
        GRANT_A: begin
          if (min_met && sensor_b_db && (!sensor_a_db || max_met)) begin
            state        <= GRANT_B;
            taorb        <= 1'b0;
            hold_cnt     <= '0;
            switch_pulse <= 1'b1;
          end
        end
        GRANT_B: begin
          if (min_met && sensor_a_db && (!sensor_b_db || max_met)) begin
            state        <= GRANT_A;
            taorb        <= 1'b1;
            hold_cnt     <= '0;
            switch_pulse <= 1'b1;
          end
        end
        default: begin
          state    <= GRANT_A;
          taorb    <= 1'b1;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_sensor_arbiter.sv
// Directed bench for traffic_sensor_arbiter with short debounce/hold times:
// reset, glitch rejection, contested alternation, min-hold and reset-on-switch.
module tb_traffic_sensor_arbiter;

  localparam int DB  = 4;
  localparam int MIN = 8;
  localparam int MAX = 20;

  logic clk = 1'b0;
  logic reset;
  logic sensor_a_raw;
  logic sensor_b_raw;
  logic taorb;
  logic sensor_a_db;
  logic sensor_b_db;
  logic switch_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  traffic_sensor_arbiter #(
    .DEBOUNCE_CYCLES(DB),
    .MIN_HOLD_CYCLES(MIN),
    .MAX_HOLD_CYCLES(MAX)
  ) dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .sensor_a_raw(sensor_a_raw),
    .sensor_b_raw(sensor_b_raw),
    .taorb       (taorb),
    .sensor_a_db (sensor_a_db),
    .sensor_b_db (sensor_b_db),
    .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got {taorb,a_db,b_db,pulse}=%b expected %b", name, act, exp);
  endtask

  function automatic logic [3:0] outs();
    return {taorb, sensor_a_db, sensor_b_db, switch_pulse};
  endfunction

  // Both streets contested from release: debounced levels high from edge 6,
  // grant toggles on every 20th edge after release.
  function automatic logic [3:0] contested(input int k);
    logic t;
    logic db;
    logic p;
    t  = ((k / MAX) % 2) == 0;
    db = (k >= DB + 2);
    p  = (k % MAX) == 0;
    return {t, db, db, p};
  endfunction

  typedef struct {
    logic       rst;
    logic       a;
    logic       b;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[20];

  initial begin
    reset        = 1'b0;
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;

    // B-only request, then A takes over once B's hold has met its minimum.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'b1000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'b1000};
    for (int i = 2; i <= 6; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 4'b1000};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'b1010};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'b1010};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'b0011};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'b0010};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 4'b0010};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 4'b0010};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 4'b0100};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 4'b0100};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 4'b0100};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 4'b0100};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 4'b1101};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 4'b1100};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 4'b1100};

    #2;
    // Reset held with both sensors high.
    sensor_a_raw = 1'b1;
    sensor_b_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", outs(), 4'b1000);
    end

    // Contested operation, then reset on the edge a switch would occur.
    reset = 1'b1;
    for (int k = 1; k < 5 * MAX; k++) begin
      tick();
      check($sformatf("contested_k%0d", k), outs(), contested(k));
    end
    reset = 1'b0;
    tick();
    check("reset_on_switch", outs(), 4'b1000);
    reset = 1'b1;
    for (int k = 1; k <= MAX + 1; k++) begin
      tick();
      check($sformatf("resume_k%0d", k), outs(), contested(k));
    end

    // Glitches of 1..3 cycles on A never reach sensor_a_db.
    reset        = 1'b0;
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int len = 1; len <= 3; len++) begin
      sensor_a_raw = 1'b1;
      for (int i = 0; i < len; i++) begin
        tick();
        check($sformatf("glitch%0d_hi", len), outs(), 4'b1000);
      end
      sensor_a_raw = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        check($sformatf("glitch%0d_lo", len), outs(), 4'b1000);
      end
    end
    sensor_a_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("stable_a_k%0d", k), outs(), (k >= DB + 2) ? 4'b1100 : 4'b1000);
    end

    // Table-driven B request / min-hold sequence.
    for (int i = 0; i < 20; i++) begin
      reset        = tbl[i].rst;
      sensor_a_raw = tbl[i].a;
      sensor_b_raw = tbl[i].b;
      tick();
      check($sformatf("tbl%0d", i), outs(), tbl[i].exp);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_arbiter.md
Name: traffic_sensor_arbiter

Overview:
- Input-side front end for the traffic light controller. It turns two raw, asynchronous, bouncy car-sensor inputs (street A, street B) into the single TAORB level that the traffic FSM consumes.
- Processing chain: synchronize each input, debounce it, then arbitrate with a minimum-hold time and a maximum-hold fairness limit, so TAORB cannot thrash.
- Runs in the 100 MHz domain. taorb feeds the top-level TAORB net in place of a raw switch.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable synchronized samples needed before a debounced level changes (10 ms at 100 MHz); must be >= 1.
- MIN_HOLD_CYCLES, 200_000_000, minimum number of cycles taorb holds a value before it may change (2 s); must be >= 1.
- MAX_HOLD_CYCLES, 1_000_000_000, cycles after which a contested grant is forced to switch (10 s); must be > MIN_HOLD_CYCLES.

Ports:
- clk_100MHz  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-low reset (0 = reset)
- sensor_a_raw  input  1  raw car sensor, street A, asynchronous, 1 = car present
- sensor_b_raw  input  1  raw car sensor, street B, asynchronous, 1 = car present
- taorb  output  1  1 = grant street A, 0 = grant street B (TAORB to the traffic FSM)
- sensor_a_db  output  1  debounced street A level
- sensor_b_db  output  1  debounced street B level
- switch_pulse  output  1  one-cycle strobe on every taorb change

Behaviour:
- One clock. All state updates on the rising edge of clk_100MHz. Reset is sampled only at the clock edge; reset=0 overrides all other activity.

Reset values:
- taorb=1; sensor_a_db=0; sensor_b_db=0; switch_pulse=0.
- Synchronizer flops cleared to 0. Debounce counters cleared to 0.
- Arbiter state = GRANT_A; hold_cnt=0.

Synchronizer:
- Two flops per input; s_x = second flop.

Debouncer (per input, independent):
- If s_x == x_db: counter cleared to 0.
- Otherwise: counter increments. When the counter equals DEBOUNCE_CYCLES-1 and s_x still differs from x_db, x_db <= s_x and the counter clears.
- A single-cycle disagreement therefore restarts the count.
- Latency from a stable raw change to the x_db change is exactly 2 + DEBOUNCE_CYCLES edges.
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles never reach x_db.

Arbiter FSM:
- States: GRANT_A (taorb=1), GRANT_B (taorb=0).
- hold_cnt increments every cycle in a state, saturating at MAX_HOLD_CYCLES-1; width $clog2(MAX_HOLD_CYCLES).
- min_met = (hold_cnt >= MIN_HOLD_CYCLES-1). max_met = (hold_cnt == MAX_HOLD_CYCLES-1).
- GRANT_A -> GRANT_B when min_met && sensor_b_db && (!sensor_a_db || max_met).
- GRANT_B -> GRANT_A when min_met && sensor_a_db && (!sensor_b_db || max_met).
- No demand, or demand only on the granted street: stay in the current state (hold_cnt keeps saturating).
- On a transition: taorb changes on that same edge, hold_cnt <= 0, switch_pulse=1 for exactly that cycle. switch_pulse is 0 otherwise.
- The arbiter reads sensor_x_db values registered on the previous edge, so taorb responds 1 cycle after the debounced change (once min_met holds).
- Both streets demanding continuously: taorb alternates every MAX_HOLD_CYCLES cycles.
- Demand that drops before min_met: no switch.
- Reset mid-operation: immediate return to the reset values, with no switch_pulse.

Test Plan (DEBOUNCE_CYCLES=4, MIN_HOLD_CYCLES=8, MAX_HOLD_CYCLES=20):
1. Hold reset=0 for 3 cycles with both sensors at 1, then release -> taorb=1, both _db=0 and switch_pulse=0 during reset; after release sensor_x_db rise 6 edges after the first sampled high.
2. Drive sensor_a_raw with glitches of 1, 2 and 3 cycles -> sensor_a_db stays 0. A 4-cycle-stable level rises exactly 6 edges after the first sample.
3. After reset, raise only sensor_b_raw -> sensor_b_db=1 at edge 6; taorb falls to 0 at edge 8 (min_met, hold_cnt=7) with a 1-cycle switch_pulse.
4. Grant B, then at hold_cnt=2 set A only -> taorb stays 0 until hold_cnt=7, then switches to 1 with a single switch_pulse.
5. Both sensors continuously high -> taorb toggles every 20 cycles; switch_pulse is high one cycle per toggle; never a toggle earlier than 20 cycles.
6. Drive reset=0 on the cycle a switch would occur -> no switch_pulse, taorb=1, hold_cnt=0; normal operation resumes after release.
